// File: rtl/divider.sv
// Sequential unsigned restoring divider, one quotient bit per cycle.
// Latency: done C_WIDTH cycles after accept (1 cycle when the divisor is zero).
// Backpressure: ready low while busy; trigger while busy is dropped, not queued.
module divider #(
  parameter int C_WIDTH = 8
) (
  input  logic               ctl_clk,
  input  logic               reset,
  input  logic               trigger,
  input  logic [C_WIDTH-1:0] a,
  input  logic [C_WIDTH-1:0] b,
  output logic [C_WIDTH-1:0] q,
  output logic [C_WIDTH-1:0] r,
  output logic               ready,
  output logic               done,
  output logic               div_by_zero
);

  localparam int CW = $clog2(C_WIDTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIN} state_t;

  state_t             state_q, state_d;
  logic [C_WIDTH-1:0] dvd_q, dvd_d;   // dividend, shifted out MSB first
  logic [C_WIDTH-1:0] dvs_q, dvs_d;   // latched divisor
  logic [C_WIDTH-1:0] rem_q, rem_d;   // partial remainder
  logic [C_WIDTH-1:0] quo_q, quo_d;   // quotient under construction
  logic [C_WIDTH-1:0] q_q, q_d;
  logic [C_WIDTH-1:0] r_q, r_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               ready_q, ready_d;
  logic               done_q, done_d;
  logic               dbz_q, dbz_d;

  logic [C_WIDTH:0]   rem_shift;
  logic [C_WIDTH:0]   rem_sub;
  logic               q_bit;

  // One restoring step; the extra top bit keeps the shifted remainder exact.
  always_comb begin
    rem_shift = {rem_q, dvd_q[C_WIDTH-1]};
    rem_sub   = rem_shift - {1'b0, dvs_q};
    q_bit     = (rem_shift >= {1'b0, dvs_q});
  end

  // Next-state and datapath control.
  always_comb begin
    state_d = state_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    q_d     = q_q;
    r_d     = r_q;
    cnt_d   = cnt_q;
    ready_d = ready_q;
    done_d  = done_q;
    dbz_d   = dbz_q;
    case (state_q)
      S_IDLE: begin
        if (trigger) begin
          dvd_d   = a;
          dvs_d   = b;
          rem_d   = '0;
          quo_d   = '0;
          cnt_d   = CW'(C_WIDTH);
          ready_d = 1'b0;
          state_d = (b != '0) ? S_CALC : S_FIN;
        end
      end
      S_CALC: begin
        dvd_d = dvd_q << 1;
        rem_d = q_bit ? rem_sub[C_WIDTH-1:0] : rem_shift[C_WIDTH-1:0];
        quo_d = {quo_q[C_WIDTH-2:0], q_bit};
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          q_d     = quo_d;
          r_d     = rem_d;
          done_d  = 1'b1;
          dbz_d   = 1'b0;
          state_d = S_FIN;
        end
      end
      S_FIN: begin
        // Entering FIN with done low means a zero divisor: publish the
        // saturated result now, then spend one more cycle as the done cycle.
        if (!done_q) begin
          q_d    = '1;
          r_d    = dvd_q;
          dbz_d  = 1'b1;
          done_d = 1'b1;
        end else begin
          done_d  = 1'b0;
          ready_d = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        ready_d = 1'b1;
        done_d  = 1'b0;
      end
    endcase
  end

  // All state registers; reset aborts any divide in flight.
  always_ff @(posedge ctl_clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      dvd_q   <= '0;
      dvs_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      q_q     <= '0;
      r_q     <= '0;
      cnt_q   <= '0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      q_q     <= q_d;
      r_q     <= r_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
      done_q  <= done_d;
      dbz_q   <= dbz_d;
    end
  end

  assign q           = q_q;
  assign r           = r_q;
  assign ready       = ready_q;
  assign done        = done_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_divider.sv
// Bench for divider: cycle-level behavioural model plus directed and random divides.
module tb_divider;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         trigger = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [W-1:0] q, r;
  logic         ready, done, dbz;

  int n_cmp  = 0;
  int n_fail = 0;

  divider #(.C_WIDTH(W)) dut (
    .ctl_clk(clk), .reset(rst), .trigger(trigger), .a(a), .b(b),
    .q(q), .r(r), .ready(ready), .done(done), .div_by_zero(dbz)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: edge-counted timeline, results from plain / and %.
  int           n = 0;
  int           done_edge = 0, free_edge = 0;
  bit           pending = 0;
  logic [W-1:0] pq = '0, pr = '0;
  logic         pd = 1'b0;
  logic [W-1:0] exp_q = '0, exp_r = '0;
  logic         exp_dbz = 1'b0, exp_done = 1'b0, exp_ready = 1'b1;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      n = 0; pending = 0;
      exp_q = '0; exp_r = '0; exp_dbz = 1'b0; exp_done = 1'b0; exp_ready = 1'b1;
    end else begin
      exp_done = 1'b0;
      if (pending && n == done_edge) begin
        exp_done = 1'b1; exp_q = pq; exp_r = pr; exp_dbz = pd;
      end
      if (pending && n == free_edge) begin
        exp_ready = 1'b1; pending = 0;
      end else if (exp_ready && trigger) begin
        exp_ready = 1'b0; pending = 1;
        if (b == 0) begin
          pq = '1; pr = a; pd = 1'b1; done_edge = n + 1;
        end else begin
          pq = a / b; pr = a % b; pd = 1'b0; done_edge = n + W;
        end
        free_edge = done_edge + 1;
      end
      n++;
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    check("done", 32'(done), 32'(exp_done));
    check("ready", 32'(ready), 32'(exp_ready));
    check("q", 32'(q), 32'(exp_q));
    check("r", 32'(r), 32'(exp_r));
    check("div_by_zero", 32'(dbz), 32'(exp_dbz));
  end

  // One divide from idle; returns the result seen on the done cycle and the latency.
  task automatic run_div(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                         output logic [W-1:0] oq, output logic [W-1:0] orr,
                         output logic od, output int lat);
    @(negedge clk);
    trigger = 1'b1; a = ta; b = tb_v;
    @(negedge clk);
    trigger = 1'b0;
    a = W'($urandom); b = W'($urandom);
    check("ready_drop", 32'(ready), 0);
    lat = 0;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    if (lat >= 40) check("done_timeout", 32'(lat), 0);
    oq = q; orr = r; od = dbz;
    @(negedge clk);
    check("ready_back", 32'(ready), 1);
    check("done_single", 32'(done), 0);
  endtask

  task automatic directed(input string name, input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                          input int eq, input int er, input int ed, input int elat);
    logic [W-1:0] oq, orr;
    logic         od;
    int           lat;
    run_div(ta, tb_v, oq, orr, od, lat);
    check({name, "_lat"}, 32'(lat), 32'(elat));
    check({name, "_q"}, 32'(oq), 32'(eq));
    check({name, "_r"}, 32'(orr), 32'(er));
    check({name, "_dbz"}, 32'(od), 32'(ed));
  endtask

  task automatic wait_ready();
    int k = 0;
    while (!ready && k < 40) begin
      @(negedge clk);
      k++;
    end
    if (k >= 40) check("ready_timeout", 32'(k), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] ra, rb, oq, orr;
    logic         od;
    int           lat, pulses, prev, cyc;

    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_ready", 32'(ready), 1);
    check("rst_done", 32'(done), 0);
    check("rst_q", 32'(q), 0);
    check("rst_r", 32'(r), 0);
    check("rst_dbz", 32'(dbz), 0);

    directed("d12_6", 8'h0C, 8'h06, 'h02, 'h00, 0, W);
    directed("d200_7", 8'd200, 8'd7, 28, 4, 0, W);
    directed("d5_9", 8'd5, 8'd9, 0, 5, 0, W);
    directed("dff_1", 8'hFF, 8'h01, 'hFF, 'h00, 0, W);
    directed("dff_80", 8'hFF, 8'h80, 'h01, 'h7F, 0, W);
    directed("dz", 8'h0C, 8'h00, 'hFF, 'h0C, 1, 1);
    directed("after_dz", 8'd50, 8'd7, 7, 1, 0, W);

    // Second trigger mid-divide with changed operands is dropped.
    @(negedge clk);
    trigger = 1'b1; a = 8'd99; b = 8'd4;
    @(negedge clk);
    trigger = 1'b0;
    @(negedge clk);
    @(negedge clk);
    trigger = 1'b1; a = 8'd17; b = 8'd3;
    @(negedge clk);
    trigger = 1'b0;
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      if (done) begin
        pulses++;
        check("retrig_q", 32'(q), 24);
        check("retrig_r", 32'(r), 3);
      end
      @(negedge clk);
    end
    check("retrig_pulses", 32'(pulses), 1);
    wait_ready();

    // Trigger held high: back-to-back divides every W+2 cycles.
    trigger = 1'b1; a = 8'd100; b = 8'd10;
    pulses = 0; prev = -1;
    for (cyc = 0; cyc < 45; cyc++) begin
      @(negedge clk);
      if (done) begin
        pulses++;
        check("b2b_q", 32'(q), 10);
        check("b2b_r", 32'(r), 0);
        if (prev >= 0) check("b2b_spacing", 32'(cyc - prev), W + 2);
        prev = cyc;
      end
    end
    check("b2b_count", 32'(pulses >= 4), 1);
    trigger = 1'b0;
    @(negedge clk);
    wait_ready();

    // Async reset part-way through a divide.
    directed("pre_rst", 8'hFF, 8'h10, 'h0F, 'h0F, 0, W);
    @(negedge clk);
    trigger = 1'b1; a = 8'h90; b = 8'h05;
    @(negedge clk);
    trigger = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_done", 32'(done), 0);
    check("arst_q", 32'(q), 0);
    check("arst_r", 32'(r), 0);
    check("arst_dbz", 32'(dbz), 0);
    check("arst_ready", 32'(ready), 1);
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (done) pulses++;
    end
    check("arst_no_done", 32'(pulses), 0);
    directed("post_rst", 8'h90, 8'h05, 28, 4, 0, W);

    // Random sweep against plain arithmetic.
    for (int i = 0; i < 500; i++) begin
      ra = W'($urandom);
      rb = ($urandom_range(0, 3) == 0) ? W'($urandom_range(1, 15)) : W'($urandom_range(1, 255));
      run_div(ra, rb, oq, orr, od, lat);
      check("rand_lat", 32'(lat), W);
      check("rand_q", 32'(oq), 32'(ra / rb));
      check("rand_r", 32'(orr), 32'(ra % rb));
      check("rand_dbz", 32'(od), 0);
    end

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
